// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with valid/ready handshakes on both sides.
// Single-cycle logic ops, iterative shifts/rotates (one bit per cycle),
// and a shift-add multiplier. Results and flags are registered and held
// until the consumer takes them.
//
// state | meaning
// IDLE  | waiting for an operation, in_ready high
// EXEC  | operation running, counter counts remaining iterations
// DONE  | result valid, held until out_ready
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       S,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             C,
  output logic             Z,
  output logic             N,
  output logic             V,
  output logic             busy
);

  localparam int CNTW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] W_VAL    = WIDTH'(WIDTH);
  localparam logic [CNTW-1:0]  CNT_FULL = CNTW'(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_SHL   = 4'd4,
    OP_SHR   = 4'd5,
    OP_XOR   = 4'd6,
    OP_NOT   = 4'd7,
    OP_ASR   = 4'd8,
    OP_ROL   = 4'd9,
    OP_ROR   = 4'd10,
    OP_MULL  = 4'd11,
    OP_MULH  = 4'd12,
    OP_CMP   = 4'd13,
    OP_RSV14 = 4'd14,
    OP_RSV15 = 4'd15
  } op_t;

  state_t             state_q;
  op_t                op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   w_q;
  logic               c_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [CNTW-1:0]    cnt_q;
  logic [WIDTH-1:0]   d_q;
  logic               cf_q;
  logic               zf_q;
  logic               nf_q;
  logic               vf_q;

  logic [CNTW-1:0]    cnt_load;
  logic [WIDTH-1:0]   rot_amt;
  logic [WIDTH-1:0]   w_step;
  logic               c_step;
  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_step;
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     dif_ext;
  logic               add_ovf;
  logic               sub_ovf;
  logic [WIDTH-1:0]   res_d;
  logic               cf_d;
  logic               zf_d;
  logic               nf_d;
  logic               vf_d;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign D         = d_q;
  assign C         = cf_q;
  assign Z         = zf_q;
  assign N         = nf_q;
  assign V         = vf_q;

  // Iteration count loaded at acceptance; shift counts saturate at WIDTH so
  // large B never costs extra cycles (the carry is then the bit shifted out
  // on the WIDTH-th step).
  always_comb begin
    rot_amt  = B % W_VAL;
    cnt_load = '0;
    case (op_t'(S))
      OP_SHL, OP_SHR, OP_ASR: cnt_load = (B >= W_VAL) ? CNT_FULL : CNTW'(B);
      OP_ROL, OP_ROR:         cnt_load = CNTW'(rot_amt);
      OP_MULL, OP_MULH:       cnt_load = CNT_FULL;
      default:                cnt_load = '0;
    endcase
  end

  // One iteration of the running shift/rotate and of the shift-add multiplier.
  always_comb begin
    w_step = w_q;
    c_step = c_q;
    case (op_q)
      OP_SHL: begin
        c_step = w_q[WIDTH-1];
        w_step = {w_q[WIDTH-2:0], 1'b0};
      end
      OP_SHR: begin
        c_step = w_q[0];
        w_step = {1'b0, w_q[WIDTH-1:1]};
      end
      OP_ASR: begin
        c_step = w_q[0];
        w_step = {w_q[WIDTH-1], w_q[WIDTH-1:1]};
      end
      OP_ROL: begin
        c_step = w_q[WIDTH-1];
        w_step = {w_q[WIDTH-2:0], w_q[WIDTH-1]};
      end
      OP_ROR: begin
        c_step = w_q[0];
        w_step = {w_q[0], w_q[WIDTH-1:1]};
      end
      default: begin
        w_step = w_q;
        c_step = c_q;
      end
    endcase
    mul_addend = prod_q[0] ? a_q : '0;
    mul_sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    prod_step  = {mul_sum, prod_q[WIDTH-1:1]};
  end

  // Final result and flags, captured when the counter reaches zero.
  always_comb begin
    sum_ext = {1'b0, a_q} + {1'b0, b_q};
    dif_ext = {1'b0, a_q} - {1'b0, b_q};
    add_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_ext[WIDTH-1] != a_q[WIDTH-1]);
    sub_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (dif_ext[WIDTH-1] != a_q[WIDTH-1]);
    res_d   = '0;
    cf_d    = 1'b0;
    vf_d    = 1'b0;
    case (op_q)
      OP_ADD: begin
        res_d = sum_ext[WIDTH-1:0];
        cf_d  = sum_ext[WIDTH];
        vf_d  = add_ovf;
      end
      OP_SUB: begin
        res_d = dif_ext[WIDTH-1:0];
        cf_d  = dif_ext[WIDTH];
        vf_d  = sub_ovf;
      end
      OP_CMP: begin
        res_d = a_q;
        cf_d  = dif_ext[WIDTH];
        vf_d  = sub_ovf;
      end
      OP_AND: res_d = a_q & b_q;
      OP_OR:  res_d = a_q | b_q;
      OP_XOR: res_d = a_q ^ b_q;
      OP_NOT: res_d = ~a_q;
      OP_SHL, OP_SHR, OP_ASR, OP_ROL, OP_ROR: begin
        res_d = w_q;
        cf_d  = c_q;
      end
      OP_MULL: begin
        res_d = prod_q[WIDTH-1:0];
        cf_d  = |prod_q[2*WIDTH-1:WIDTH];
      end
      OP_MULH: res_d = prod_q[2*WIDTH-1:WIDTH];
      default: res_d = '0;
    endcase
    zf_d = (res_d == '0);
    nf_d = res_d[WIDTH-1];
    if (op_q == OP_CMP) begin
      zf_d = (dif_ext[WIDTH-1:0] == '0);
      nf_d = dif_ext[WIDTH-1];
    end else if (op_q == OP_RSV14 || op_q == OP_RSV15) begin
      zf_d = 1'b0;
      nf_d = 1'b0;
    end
  end

  // Control FSM with the operand, working and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      w_q     <= '0;
      c_q     <= 1'b0;
      prod_q  <= '0;
      cnt_q   <= '0;
      d_q     <= '0;
      cf_q    <= 1'b0;
      zf_q    <= 1'b0;
      nf_q    <= 1'b0;
      vf_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            op_q    <= op_t'(S);
            a_q     <= A;
            b_q     <= B;
            w_q     <= A;
            c_q     <= 1'b0;
            prod_q  <= {{WIDTH{1'b0}}, B};
            cnt_q   <= cnt_load;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt_q == '0) begin
            d_q     <= res_d;
            cf_q    <= cf_d;
            zf_q    <= zf_d;
            nf_q    <= nf_d;
            vf_q    <= vf_d;
            state_q <= ST_DONE;
          end else begin
            cnt_q  <= cnt_q - CNTW'(1);
            w_q    <= w_step;
            c_q    <= c_step;
            prod_q <= prod_step;
          end
        end
        ST_DONE: begin
          if (out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
